// File: rtl/dds_pkg.sv
// Shared widths, default tuning increment and controller state encoding for the DDS block.
// The phase accumulator imports ACC_W and BASE_TUNE from here as well.
package dds_pkg;
    localparam int ACC_W     = 28;
    localparam int CODE_W    = 10;
    localparam int DEC_W     = 16;
    localparam int BASE_TUNE = 26844;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_STOP = 2'd1,
        SWEEP    = 2'd2
    } dds_state_e;
endpackage

// File: rtl/key_debounce.sv
// Synchronizes the asynchronous active-low key and emits one press pulse per
// debounced high-to-low transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // r_stable holds the debounced key level (1 = released); r_cnt counts how
    // long the synchronized key has disagreed with it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign press = r_press;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Tuning-word controller: manual single-code loads or a dwell-timed start/stop sweep,
// turned into a 28-bit tuning word for the phase accumulator.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int BASE_TUNE_P     = BASE_TUNE,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 5000000,
    parameter int STEP_CODE       = 1,
    parameter int LOOP            = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CODE_W-1:0] sw,
    input  logic              set_n,
    input  logic              mode,
    output logic [ACC_W-1:0]  tuner,
    output logic [DEC_W-1:0]  dec_val,
    output logic              tune_load,
    output logic              busy,
    output logic              sweep_done,
    output logic [1:0]        dbg_state
);
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0]   DW_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [CODE_W-1:0] STEP    = CODE_W'(STEP_CODE);

    dds_state_e        r_state, w_state_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic [CODE_W-1:0] r_start, w_start_nxt;
    logic [CODE_W-1:0] r_stop, w_stop_nxt;
    logic [DW_W-1:0]   r_dwell, w_dwell_nxt;
    logic              w_code_wr, r_code_wr;
    logic              w_done, r_done;
    logic [ACC_W-1:0]  r_tuner;
    logic              r_tune_load;
    logic              w_set_evt;
    logic [CODE_W-1:0] w_step_code;
    logic [ACC_W-1:0]  w_prod;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (clk),
        .clr   (clr),
        .key_n (set_n),
        .press (w_set_evt)
    );

    // Next sweep code, clamped so the stop code is always landed on exactly.
    always_comb begin
        w_step_code = r_stop;
        if (r_code < r_stop) begin
            if ((r_stop - r_code) > STEP) w_step_code = r_code + STEP;
        end else if (r_code > r_stop) begin
            if ((r_code - r_stop) > STEP) w_step_code = r_code - STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_code_wr   = 1'b0;
        w_start_nxt = r_start;
        w_stop_nxt  = r_stop;
        w_dwell_nxt = r_dwell;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_set_evt) begin
                    if (mode) begin
                        w_start_nxt = sw;
                        w_state_nxt = GET_STOP;
                    end else begin
                        w_code_nxt = sw;
                        w_code_wr  = 1'b1;
                    end
                end
            end
            GET_STOP: begin
                if (w_set_evt) begin
                    w_stop_nxt  = sw;
                    w_code_nxt  = r_start;
                    w_code_wr   = 1'b1;
                    w_dwell_nxt = '0;
                    w_state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (w_set_evt) begin
                    w_state_nxt = IDLE;
                end else if (r_dwell == DW_LAST) begin
                    w_dwell_nxt = '0;
                    if (r_code == r_stop) begin
                        if (LOOP != 0) begin
                            w_code_nxt = r_start;
                            w_code_wr  = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_done      = 1'b1;
                        end
                    end else begin
                        w_code_nxt = w_step_code;
                        w_code_wr  = 1'b1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_prod = ACC_W'(r_code) * ACC_W'(BASE_TUNE_P);

    // tuner follows the code one cycle later; tune_load marks every write, even same-value ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_code      <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_dwell     <= '0;
            r_code_wr   <= 1'b0;
            r_done      <= 1'b0;
            r_tuner     <= '0;
            r_tune_load <= 1'b0;
        end else begin
            r_code      <= w_code_nxt;
            r_start     <= w_start_nxt;
            r_stop      <= w_stop_nxt;
            r_dwell     <= w_dwell_nxt;
            r_code_wr   <= w_code_wr;
            r_done      <= w_done;
            r_tune_load <= r_code_wr;
            if (r_code_wr) r_tuner <= w_prod;
        end
    end

    assign tuner      = r_tuner;
    assign dec_val    = {{(DEC_W - CODE_W){1'b0}}, r_code};
    assign tune_load  = r_tune_load;
    assign busy       = (r_state == GET_STOP) || (r_state == SWEEP);
    assign sweep_done = r_done;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: three instances (step 1 / step 2 / looping) share stimulus;
// expected tuning words are queued at stimulus time and popped on each tune_load.
module tb_dds_sweep_ctrl;
    localparam int BT    = 26844;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        set_n;
    logic        mode;
    logic [9:0]  sw;
    logic [27:0] t_tuner [3];
    logic [15:0] t_dec   [3];
    logic        t_load  [3];
    logic        t_busy  [3];
    logic        t_done  [3];
    logic [1:0]  t_state [3];

    int sel = 0;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_load = 0;
    int done_cyc = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    bit sb_free = 1'b0;
    logic [43:0] exp_q[$];
    logic [43:0] mon_e;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(DWELL), .STEP_CODE(1), .LOOP(0)) dut0 (
        .clk(clk), .clr(clr), .sw(sw), .set_n(set_n), .mode(mode),
        .tuner(t_tuner[0]), .dec_val(t_dec[0]), .tune_load(t_load[0]),
        .busy(t_busy[0]), .sweep_done(t_done[0]), .dbg_state(t_state[0]));

    dds_sweep_ctrl #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(DWELL), .STEP_CODE(2), .LOOP(0)) dut1 (
        .clk(clk), .clr(clr), .sw(sw), .set_n(set_n), .mode(mode),
        .tuner(t_tuner[1]), .dec_val(t_dec[1]), .tune_load(t_load[1]),
        .busy(t_busy[1]), .sweep_done(t_done[1]), .dbg_state(t_state[1]));

    dds_sweep_ctrl #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(DWELL), .STEP_CODE(1), .LOOP(1)) dut2 (
        .clk(clk), .clr(clr), .sw(sw), .set_n(set_n), .mode(mode),
        .tuner(t_tuner[2]), .dec_val(t_dec[2]), .tune_load(t_load[2]),
        .busy(t_busy[2]), .sweep_done(t_done[2]), .dbg_state(t_state[2]));

    function automatic logic [27:0] tw(input int c);
        return 28'(c * BT);
    endfunction

    // Scoreboard monitor on the selected instance; entry = {expected gap, expected tuner}.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (t_load[sel]) begin
            load_cnt = load_cnt + 1;
            if (!sb_free) begin
                n_tests = n_tests + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_unexpected_load: tuner=%0d, required no load", t_tuner[sel]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (t_tuner[sel] !== mon_e[27:0]) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_tuner: got %0d, required %0d", t_tuner[sel], mon_e[27:0]);
                    end else if (mon_e[43:28] != 16'd0 && (cyc - last_load) != int'(mon_e[43:28])) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_hold: held %0d cycles, required %0d", cyc - last_load, mon_e[43:28]);
                    end
                end
            end
            last_load = cyc;
        end
        if (t_done[sel]) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        set_n = 1'b1;
        tick(2);
        clr = 1'b0;
        exp_q.delete();
        load_cnt = 0;
        done_cnt = 0;
        sb_free = 1'b0;
    endtask

    task automatic push(input int code, input int gap);
        exp_q.push_back({16'(gap), tw(code)});
    endtask

    task automatic press(input int code, input logic m);
        sw = 10'(code);
        mode = m;
        set_n = 1'b0;
        tick(10);
        set_n = 1'b1;
        sw = 10'($urandom_range(0, 1023));
        mode = 1'($urandom_range(0, 1));
        tick(10);
    endtask

    task automatic wait_empty(input string name, input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d loads outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int k = 0;
        while (done_cnt == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no sweep_done within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        sw = 10'($urandom_range(0, 1023));
        mode = 1'b1;
        do_reset();
        @(negedge clk);
        n_tests += 6;
        if (t_tuner[0] !== 28'd0) begin n_fail++; $display("FAIL rst_tuner: got %0d, required 0", t_tuner[0]); end
        if (t_dec[0] !== 16'd0) begin n_fail++; $display("FAIL rst_dec: got %0d, required 0", t_dec[0]); end
        if (t_load[0] !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b, required 0", t_load[0]); end
        if (t_busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", t_busy[0]); end
        if (t_done[0] !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", t_done[0]); end
        if (t_state[0] !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", t_state[0]); end
    endtask

    task automatic test_manual();
        int k = 0;
        sel = 0;
        do_reset();
        sw = 10'd10;
        mode = 1'b0;
        push(10, 0);
        set_n = 1'b0;
        while (!dut0.u_key.press && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!dut0.u_key.press) begin
            n_fail++;
            $display("FAIL man_press_timeout: no debounced press within 20 cycles");
        end
        @(negedge clk);
        n_tests += 2;
        if (t_dec[0] !== 16'd10) begin n_fail++; $display("FAIL man_dec_lat: got %0d, required 10", t_dec[0]); end
        if (t_load[0] !== 1'b0) begin n_fail++; $display("FAIL man_load_early: got %b, required 0", t_load[0]); end
        @(negedge clk);
        n_tests++;
        if (t_load[0] !== 1'b1 || t_tuner[0] !== 28'd268440) begin
            n_fail++;
            $display("FAIL man_tuner_lat: load=%b tuner=%0d, required 1 and 268440", t_load[0], t_tuner[0]);
        end
        tick(4);
        set_n = 1'b1;
        tick(12);
        n_tests++;
        if (load_cnt != 1) begin n_fail++; $display("FAIL man_one_load: got %0d loads, required 1", load_cnt); end
        wait_empty("man", 4);
    endtask

    task automatic test_bounce();
        int lc;
        sel = 0;
        lc = load_cnt;
        sw = 10'd77;
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_n = 1'b0;
            tick(2);
            set_n = 1'b1;
            tick(2);
        end
        tick(10);
        n_tests += 2;
        if (load_cnt != lc) begin n_fail++; $display("FAIL bounce_load: got %0d loads, required %0d", load_cnt, lc); end
        if (t_tuner[0] !== tw(10)) begin n_fail++; $display("FAIL bounce_tuner: got %0d, required %0d", t_tuner[0], tw(10)); end
    endtask

    task automatic test_sweep_up();
        sel = 0;
        do_reset();
        press(3, 1'b1);
        n_tests += 2;
        if (t_busy[0] !== 1'b1) begin n_fail++; $display("FAIL up_busy_getstop: got %b, required 1", t_busy[0]); end
        if (t_state[0] !== 2'd1) begin n_fail++; $display("FAIL up_state_getstop: got %0d, required 1", t_state[0]); end
        push(3, 0); push(4, DWELL); push(5, DWELL);
        press(5, 1'b0);
        wait_empty("up", 60);
        wait_done("up", 60);
        @(negedge clk);
        n_tests += 4;
        if (done_cyc - last_load != DWELL - 1) begin n_fail++; $display("FAIL up_done_time: got %0d, required %0d", done_cyc - last_load, DWELL - 1); end
        if (t_busy[0] !== 1'b0) begin n_fail++; $display("FAIL up_busy_end: got %b, required 0", t_busy[0]); end
        if (t_tuner[0] !== 28'd134220) begin n_fail++; $display("FAIL up_tuner_end: got %0d, required 134220", t_tuner[0]); end
        if (t_dec[0] !== 16'd5) begin n_fail++; $display("FAIL up_dec_end: got %0d, required 5", t_dec[0]); end
        tick(10);
        n_tests += 2;
        if (done_cnt != 1) begin n_fail++; $display("FAIL up_done_cnt: got %0d, required 1", done_cnt); end
        if (load_cnt != 3 || t_tuner[0] !== 28'd134220) begin
            n_fail++;
            $display("FAIL up_hold_end: loads=%0d tuner=%0d, required 3 and 134220", load_cnt, t_tuner[0]);
        end
    endtask

    task automatic test_sweep_down();
        sel = 1;
        do_reset();
        press(7, 1'b1);
        push(7, 0); push(5, DWELL); push(3, DWELL); push(2, DWELL);
        press(2, 1'b1);
        wait_empty("down", 60);
        wait_done("down", 60);
        tick(6);
        n_tests += 3;
        if (done_cnt != 1) begin n_fail++; $display("FAIL down_done_cnt: got %0d, required 1", done_cnt); end
        if (t_dec[1] !== 16'd2) begin n_fail++; $display("FAIL down_dec_end: got %0d, required 2", t_dec[1]); end
        if (t_busy[1] !== 1'b0) begin n_fail++; $display("FAIL down_busy_end: got %b, required 0", t_busy[1]); end
    endtask

    task automatic test_single();
        sel = 0;
        do_reset();
        press(4, 1'b1);
        push(4, 0);
        press(4, 1'b1);
        wait_empty("single", 40);
        wait_done("single", 40);
        tick(2);
        n_tests += 2;
        if (done_cyc - last_load != DWELL - 1) begin n_fail++; $display("FAIL single_done_time: got %0d, required %0d", done_cyc - last_load, DWELL - 1); end
        if (t_busy[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, required 0", t_busy[0]); end
    endtask

    task automatic test_loop();
        int lc;
        logic [15:0] d;
        sel = 2;
        do_reset();
        press(1, 1'b1);
        push(1, 0);
        for (int i = 0; i < 5; i++) push((i % 2 == 0) ? 2 : 1, DWELL);
        press(2, 1'b0);
        wait_empty("loop", 80);
        sb_free = 1'b1;
        press(0, 1'b0);
        d = t_dec[2];
        lc = load_cnt;
        n_tests += 4;
        if (t_busy[2] !== 1'b0 || t_state[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL loop_abort_state: busy=%b state=%0d, required 0 and 0", t_busy[2], t_state[2]);
        end
        if (done_cnt != 0) begin n_fail++; $display("FAIL loop_no_done: got %0d pulses, required 0", done_cnt); end
        if (d != 16'd1 && d != 16'd2) begin n_fail++; $display("FAIL loop_abort_code: got %0d, required 1 or 2", d); end
        if (t_tuner[2] !== tw(int'(d))) begin n_fail++; $display("FAIL loop_abort_tuner: got %0d, required %0d", t_tuner[2], tw(int'(d))); end
        tick(12);
        n_tests += 2;
        if (load_cnt != lc) begin n_fail++; $display("FAIL loop_frozen_load: got %0d loads, required %0d", load_cnt, lc); end
        if (t_dec[2] !== d) begin n_fail++; $display("FAIL loop_frozen_code: got %0d, required %0d", t_dec[2], d); end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        sb_free = 1'b1;
        press(3, 1'b1);
        press(9, 1'b0);
        n_tests++;
        if (t_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b, required 1", t_busy[0]); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (t_tuner[0] !== 28'd0) begin n_fail++; $display("FAIL rmid_tuner: got %0d, required 0", t_tuner[0]); end
        if (t_dec[0] !== 16'd0) begin n_fail++; $display("FAIL rmid_dec: got %0d, required 0", t_dec[0]); end
        if (t_busy[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", t_busy[0]); end
        if (t_state[0] !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d, required 0", t_state[0]); end
        exp_q.delete();
        done_cnt = 0;
        sb_free = 1'b0;
        push(1023, 0);
        press(1023, 1'b0);
        wait_empty("rmid_max", 10);
        push(0, 0);
        press(0, 1'b0);
        wait_empty("rmid_zero", 10);
        n_tests += 2;
        if (t_tuner[0] !== 28'd0) begin n_fail++; $display("FAIL rmid_zero_tuner: got %0d, required 0", t_tuner[0]); end
        if (done_cnt != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses, required 0", done_cnt); end
    endtask

    initial begin
        clr = 1'b1;
        set_n = 1'b1;
        mode = 1'b0;
        sw = 10'd0;
        test_reset();
        test_manual();
        test_bounce();
        test_sweep_up();
        test_sweep_down();
        test_single();
        test_loop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
